// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle between the pipeline and hazard_ctrl.
// master: pipeline side (drives register ids / control bits, receives stall/flush).
// slave : hazard unit side (consumes pipeline state, drives stall/flush/status).
interface hazard_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  // Register ids and control bits from D/E/M
  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic [REG_W-1:0] write_reg_e;
  logic [REG_W-1:0] write_reg_m;
  logic             reg_write_e;
  logic             mem_to_reg_e;
  logic             mem_to_reg_m;
  logic             branch_d;

  // Data-memory handshake seen by M
  logic             mem_req_m;
  logic             mem_ready;

  // Pipeline control and status
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_e;
  logic             flush_w;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output rs_d, rt_d, write_reg_e, write_reg_m,
    output reg_write_e, mem_to_reg_e, mem_to_reg_m, branch_d,
    output mem_req_m, mem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_e, flush_w,
    input  mem_timeout, stall_count
  );

  modport slave (
    input  rs_d, rt_d, write_reg_e, write_reg_m,
    input  reg_write_e, mem_to_reg_e, mem_to_reg_m, branch_d,
    input  mem_req_m, mem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_e, flush_w,
    output mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-compare stalls, data-memory
// wait stalls with a timeout FSM, and a saturating stall-cycle counter.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - hazard_ctrl_if.slave (pipeline register ids/control in,
//           stall/flush/mem_timeout/stall_count out)
// Stall and flush outputs are combinational (zero-cycle) from inputs and state.
module hazard_ctrl (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_count;

  logic lwstall;
  logic brstall;
  logic e_hit;
  logic m_hit;
  logic memwait;
  logic hazard;

  // Dependency detection; register 0 is hardwired and never creates a hazard
  always_comb begin
    lwstall = bus.mem_to_reg_e && (bus.write_reg_e != '0) &&
              ((bus.write_reg_e == bus.rs_d) || (bus.write_reg_e == bus.rt_d));
    e_hit   = bus.reg_write_e && (bus.write_reg_e != '0) &&
              ((bus.write_reg_e == bus.rs_d) || (bus.write_reg_e == bus.rt_d));
    m_hit   = bus.mem_to_reg_m && (bus.write_reg_m != '0) &&
              ((bus.write_reg_m == bus.rs_d) || (bus.write_reg_m == bus.rt_d));
    brstall = bus.branch_d && (e_hit || m_hit);
    hazard  = lwstall || brstall;
  end

  // Memory wait: a completing access (mem_ready) releases in the same cycle
  always_comb begin
    memwait = 1'b0;
    case (state)
      IDLE:    memwait = bus.mem_req_m && !bus.mem_ready;
      WAIT:    memwait = !bus.mem_ready;
      ERR:     memwait = 1'b1;
      default: memwait = 1'b0;
    endcase
  end

  // Stall/flush decode; a memory wait holds E rather than bubbling it
  always_comb begin
    bus.stall_f = 1'b0;
    bus.stall_d = 1'b0;
    bus.stall_e = 1'b0;
    bus.stall_m = 1'b0;
    bus.flush_e = 1'b0;
    bus.flush_w = 1'b0;
    if (!reset) begin
      if (memwait) begin
        bus.stall_f = 1'b1;
        bus.stall_d = 1'b1;
        bus.stall_e = 1'b1;
        bus.stall_m = 1'b1;
        bus.flush_w = 1'b1;
      end else begin
        bus.stall_f = hazard;
        bus.stall_d = hazard;
        bus.flush_e = hazard;
      end
    end
  end

  // Memory-wait FSM with timeout into a sticky error state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req_m && !bus.mem_ready) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            state <= IDLE;
          end else if (wait_cnt == {WAIT_W{1'b1}}) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (bus.stall_f && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_count;
  assign bus.mem_timeout = (state == ERR);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations are queued when a step is driven
// and popped/compared once the DUT outputs have settled.
module tb_hazard_ctrl;
  logic clk;
  logic reset;

  hazard_ctrl_if bus();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        sf, sd, se, sm, fe, fw, to;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [15:0] exp_cnt = 16'h0;

  task automatic cmp(input string tag, input string field,
                     input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
  endtask

  task automatic clear_in();
    bus.rs_d         = '0;
    bus.rt_d         = '0;
    bus.write_reg_e  = '0;
    bus.write_reg_m  = '0;
    bus.reg_write_e  = 1'b0;
    bus.mem_to_reg_e = 1'b0;
    bus.mem_to_reg_m = 1'b0;
    bus.branch_d     = 1'b0;
    bus.mem_req_m    = 1'b0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic set_lw();
    bus.mem_to_reg_e = 1'b1;
    bus.write_reg_e  = 5'd8;
    bus.rs_d         = 5'd8;
  endtask

  // Queue the expected outputs for the step just driven, then compare after settle
  task automatic check(input string tag, input logic sf, input logic sd,
                       input logic se, input logic sm, input logic fe,
                       input logic fw, input logic to);
    exp_t e;
    exp_t got;
    if (reset) exp_cnt = 16'h0;
    e.tag = tag; e.sf = sf; e.sd = sd; e.se = se; e.sm = sm;
    e.fe = fe; e.fw = fw; e.to = to; e.cnt = exp_cnt;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    cmp(got.tag, "stall_f",     16'(bus.stall_f),     16'(got.sf));
    cmp(got.tag, "stall_d",     16'(bus.stall_d),     16'(got.sd));
    cmp(got.tag, "stall_e",     16'(bus.stall_e),     16'(got.se));
    cmp(got.tag, "stall_m",     16'(bus.stall_m),     16'(got.sm));
    cmp(got.tag, "flush_e",     16'(bus.flush_e),     16'(got.fe));
    cmp(got.tag, "flush_w",     16'(bus.flush_w),     16'(got.fw));
    cmp(got.tag, "mem_timeout", 16'(bus.mem_timeout), 16'(got.to));
    cmp(got.tag, "stall_count", bus.stall_count,      got.cnt);
    // Next rising edge counts this cycle if fetch is stalled
    if (!reset && sf && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_in();
    set_lw();
    @(negedge clk);
    check("reset_lw", 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk); reset = 1'b0; clear_in();
    check("idle", 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk); clear_in(); set_lw();
    check("lw_rs", 1, 1, 0, 0, 1, 0, 0);

    @(negedge clk); clear_in();
    bus.mem_to_reg_e = 1'b1; bus.write_reg_e = 5'd8; bus.rs_d = 5'd3; bus.rt_d = 5'd8;
    check("lw_rt", 1, 1, 0, 0, 1, 0, 0);

    @(negedge clk); clear_in();
    bus.mem_to_reg_e = 1'b1; bus.mem_to_reg_m = 1'b1; bus.reg_write_e = 1'b1;
    bus.branch_d = 1'b1;
    check("reg0", 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk); clear_in();
    bus.branch_d = 1'b1; bus.reg_write_e = 1'b1; bus.write_reg_e = 5'd9; bus.rt_d = 5'd9;
    check("br_e", 1, 1, 0, 0, 1, 0, 0);

    @(negedge clk); clear_in();
    bus.branch_d = 1'b1; bus.reg_write_e = 1'b1; bus.write_reg_e = 5'd0; bus.rt_d = 5'd0;
    check("br_e_r0", 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk); clear_in();
    bus.branch_d = 1'b1; bus.mem_to_reg_m = 1'b1; bus.write_reg_m = 5'd12; bus.rs_d = 5'd12;
    check("br_m", 1, 1, 0, 0, 1, 0, 0);

    @(negedge clk); clear_in();
    bus.reg_write_e = 1'b1; bus.write_reg_e = 5'd9; bus.rt_d = 5'd9;
    check("alu_nobranch", 0, 0, 0, 0, 0, 0, 0);

    // Three-cycle memory wait, then same-cycle release
    @(negedge clk); clear_in(); bus.mem_req_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("memwait_%0d", i), 1, 1, 1, 1, 0, 1, 0);
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    check("mem_ready", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); clear_in();
    check("back_idle", 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk); clear_in(); bus.mem_req_m = 1'b1; bus.mem_ready = 1'b1;
    check("req_ready_idle", 0, 0, 0, 0, 0, 0, 0);

    // Load-use hazard coinciding with a memory wait
    @(negedge clk); clear_in(); set_lw(); bus.mem_req_m = 1'b1;
    check("lw_wait_0", 1, 1, 1, 1, 0, 1, 0);
    @(negedge clk);
    check("lw_wait_1", 1, 1, 1, 1, 0, 1, 0);
    @(negedge clk); bus.mem_ready = 1'b1;
    check("lw_ready", 1, 1, 0, 0, 1, 0, 0);
    @(negedge clk); bus.mem_req_m = 1'b0; bus.mem_ready = 1'b0;
    check("lw_after", 1, 1, 0, 0, 1, 0, 0);

    // Timeout: 17 cycles without ready lands in ERR
    @(negedge clk); clear_in(); bus.mem_req_m = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("tmo_%0d", i), 1, 1, 1, 1, 0, 1, 0);
      @(negedge clk);
    end
    bus.mem_req_m = 1'b0; bus.mem_ready = 1'b1;
    check("err", 1, 1, 1, 1, 0, 1, 1);
    @(negedge clk);
    check("err_sticky", 1, 1, 1, 1, 0, 1, 1);

    @(negedge clk); reset = 1'b1;
    check("err_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0; clear_in();
    check("err_reset_idle", 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a wait
    @(negedge clk); bus.mem_req_m = 1'b1;
    check("mid_wait_0", 1, 1, 1, 1, 0, 1, 0);
    @(negedge clk);
    check("mid_wait_1", 1, 1, 1, 1, 0, 1, 0);
    @(negedge clk); reset = 1'b1;
    check("mid_wait_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0; bus.mem_req_m = 1'b0;
    check("mid_wait_idle", 0, 0, 0, 0, 0, 0, 0);

    // Saturation: 65535 stalled edges fill the counter, one more must hold it
    @(negedge clk); clear_in(); set_lw();
    exp_cnt = 16'h0;
    repeat (65535) @(negedge clk);
    exp_cnt = 16'hFFFF;
    check("sat_full", 1, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("sat_hold", 1, 1, 0, 0, 1, 0, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately when reset=1.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 rs_d, rt_d  in  5 each  source registers of the instruction in D.
REQ-005 write_reg_e, write_reg_m  in  5 each  destination registers in E and M.
REQ-006 reg_write_e, mem_to_reg_e, mem_to_reg_m  in  1 each  control bits in E/M.
REQ-007 branch_d  in  1  D holds a branch that compares in D.
REQ-008 mem_req_m, mem_ready  in  1 each  M issues data-memory access; memory acknowledges.
REQ-009 stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-010 flush_e, flush_w  out  1 each  insert a bubble into ID/EX and MEM/WB.
REQ-011 mem_timeout  out  1  sticky memory-timeout error.
REQ-012 stall_count  out  16  saturating count of stall_f cycles.

Function
REQ-013 lwstall SHALL be mem_to_reg_e & write_reg_e!=0 & (write_reg_e==rs_d | write_reg_e==rt_d).
REQ-014 brstall SHALL be branch_d & ((reg_write_e & write_reg_e!=0 & write_reg_e in {rs_d,rt_d}) | (mem_to_reg_m & write_reg_m!=0 & write_reg_m in {rs_d,rt_d})).
REQ-015 The FSM SHALL have states IDLE, WAIT and ERR; the reset state SHALL be IDLE.
REQ-016 memwait SHALL be (IDLE & mem_req_m & ~mem_ready) | (WAIT & ~mem_ready) | ERR.
REQ-017 IDLE -> WAIT when mem_req_m & ~mem_ready; IDLE & mem_req_m & mem_ready SHALL stay in IDLE with zero stall.
REQ-018 WAIT -> IDLE when mem_ready; memwait SHALL be 0 in that cycle, so release is same-cycle.
REQ-019 A 4-bit wait_cnt SHALL clear on IDLE->WAIT and increment each WAIT cycle with ~mem_ready.
REQ-020 When wait_cnt==15 and mem_ready=0, the FSM SHALL go WAIT -> ERR; ERR SHALL be left only by reset.
REQ-021 When memwait=1, stall_f, stall_d, stall_e and stall_m SHALL be 1, flush_w SHALL be 1, and flush_e SHALL be 0, so E is held and not bubbled.
REQ-022 When memwait=0, stall_f and stall_d SHALL equal lwstall|brstall, flush_e SHALL equal lwstall|brstall, and stall_e, stall_m and flush_w SHALL be 0.
REQ-023 All stall/flush outputs SHALL be combinational from the inputs and state, with zero-cycle latency.
REQ-024 mem_timeout SHALL be 1 exactly while state==ERR.
REQ-025 stall_count SHALL increment on each clock edge where stall_f=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-026 Register 0 SHALL never cause a stall, even when control bits are asserted.

Reset
REQ-027 During reset, state SHALL be IDLE, wait_cnt 0, stall_count 0 and mem_timeout 0.
REQ-028 While reset=1, all stall/flush outputs SHALL be 0 regardless of inputs.
REQ-029 Reset asserted mid-WAIT or in ERR SHALL return to IDLE asynchronously; the first edge after deassertion SHALL evaluate from IDLE.

Verification
REQ-030 Load-use: mem_to_reg_e=1, write_reg_e=8, rs_d=8 -> stall_f=stall_d=flush_e=1, stall_e=0, stall_count +1.
REQ-031 Branch: branch_d=1, reg_write_e=1, write_reg_e=9, rt_d=9 -> stall_f=stall_d=flush_e=1. With write_reg_e=0 -> all 0.
REQ-032 Memory wait: mem_req_m=1, mem_ready=0 for 3 cycles then 1 -> all four stalls and flush_w =1 for 3 cycles, flush_e=0, 0 on the ready cycle, FSM returns to IDLE.
REQ-033 Simultaneous events: lwstall=1 during WAIT -> flush_e=0 and stall_e=1. After the ready cycle, lwstall alone SHALL be reflected.
REQ-034 Timeout: mem_ready held 0 for 17 cycles -> ERR entered after wait_cnt reaches 15, mem_timeout=1, stalls stay 1; asserting reset gives mem_timeout=0 and outputs 0.
REQ-035 Saturation: stall_count preloaded by 65535 stall cycles, then 1 more -> stall_count stays 16'hFFFF.
